// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: run-time width sign/zero extender with post-shift and overflow flag,
// registered through a 2-entry valid/ready buffer.
module imm_extend_pipe #(
  parameter int IN_W = 24,
  parameter int OUT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_data,
  input  logic [$clog2(IN_W+1)-1:0]  in_len,
  input  logic                       in_signed,
  input  logic [1:0]                 in_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_ovf
);
  localparam int LW = $clog2(IN_W+1);
  logic [LW-1:0] lenEff;
  logic [OUT_W-1:0] dataW, mask, ext, res;
  logic signBit, ovf;
  logic [OUT_W+2:0] wide;
  always_comb begin
    lenEff = (in_len == '0 || in_len > LW'(IN_W)) ? LW'(IN_W) : in_len;
    dataW = OUT_W'(in_data);
    mask = ~({OUT_W{1'b1}} << lenEff);
    signBit = in_signed & |(dataW & (mask ^ (mask >> 1)));
    ext = (dataW & mask) | (signBit ? ~mask : '0);
    wide = {{3{signBit}}, ext} << in_shift;
    res = wide[OUT_W-1:0];
    ovf = in_signed ? (wide[OUT_W+2:OUT_W] != {3{res[OUT_W-1]}}) : |wide[OUT_W+2:OUT_W];
  end
  logic [OUT_W-1:0] memData [2];
  logic memOvf [2];
  logic rdPtr, wrPtr, rdyEn, push, pop;
  logic [1:0] cnt;
  // rdyEn keeps in_ready low during reset and lets it rise on the first edge after release
  assign in_ready = rdyEn & (cnt != 2'd2);
  assign out_valid = cnt != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = memData[rdPtr];
  assign out_ovf = memOvf[rdPtr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memData[0] <= '0;
      memData[1] <= '0;
      memOvf[0] <= 1'b0;
      memOvf[1] <= 1'b0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      rdyEn <= 1'b0;
      cnt <= 2'd0;
    end else begin
      rdyEn <= 1'b1;
      if (push) begin
        memData[wrPtr] <= res;
        memOvf[wrPtr] <= ovf;
        wrPtr <= ~wrPtr;
      end
      if (pop) rdPtr <= ~rdPtr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: randomized and directed checks of imm_extend_pipe against an arithmetic model.
module tb_imm_extend_pipe;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_signed = 0, out_valid, out_ready = 0, out_ovf;
  logic [23:0] in_data = 0;
  logic [4:0] in_len = 0;
  logic [1:0] in_shift = 0;
  logic [31:0] out_data;
  logic validW = 0, readyW, signedW = 0, outValidW, outReadyW = 1, outOvfW;
  logic [31:0] dataW = 0, outDataW;
  logic [5:0] lenW = 0;
  logic [1:0] shiftW = 0;
  int nChecks = 0, nFail = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(24), .OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_len(in_len), .in_signed(in_signed), .in_shift(in_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf));

  imm_extend_pipe #(.IN_W(32), .OUT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(validW), .in_ready(readyW), .in_data(dataW),
    .in_len(lenW), .in_signed(signedW), .in_shift(shiftW), .out_valid(outValidW),
    .out_ready(outReadyW), .out_data(outDataW), .out_ovf(outOvfW));

  // {ovf, data}: extend as an integer value, multiply by 2**sh, check the OUT_W range
  function automatic logic [32:0] model(longint data, int len, int w, bit sgn, int sh);
    int l;
    longint f, v, p;
    logic [63:0] pb;
    bit o;
    l = (len == 0 || len > w) ? w : len;
    f = data & ((longint'(1) << l) - 1);
    v = (sgn && f[l-1]) ? f - (longint'(1) << l) : f;
    p = v * (longint'(1) << sh);
    pb = p;
    o = sgn ? (p < -(longint'(1) << 31) || p >= (longint'(1) << 31)) : (p >= (longint'(1) << 32));
    return {o, pb[31:0]};
  endfunction

  task automatic tick();
    bit acc, pp;
    logic [32:0] e;
    acc = in_valid && in_ready;
    pp = out_valid && out_ready;
    e = model(longint'(in_data), int'(in_len), 24, in_signed, int'(in_shift));
    @(posedge clk);
    if (pp && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++;
    if ({out_valid, in_ready, out_ovf, out_data} !== 35'd0) begin
      nFail++; $display("FAIL reset_hold: got v=%b r=%b o=%b d=%h want all zero", out_valid, in_ready, out_ovf, out_data);
    end
    #2 rst_n = 1;
    #1 nChecks++;
    if (in_ready !== 1'b0) begin nFail++; $display("FAIL reset_release_early: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    nChecks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nFail++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [23:0] d [5] = '{24'h002000, 24'h800000, 24'h800000, 24'hFF2000, 24'h003FFF};
    logic [4:0] l [5] = '{5'd14, 5'd0, 5'd0, 5'd14, 5'd14};
    bit s [5] = '{1, 1, 0, 0, 1};
    logic [1:0] sh [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [32:0] ex [5] = '{33'h0FFFFE000, 33'h0FF800000, 33'h000800000, 33'h000002000, 33'h0FFFFFFFC};
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = d[i]; in_len = l[i]; in_signed = s[i]; in_shift = sh[i]; in_valid = 1;
      tick();
      in_valid = 0;
      nChecks++;
      if (out_valid !== 1'b1 || {out_ovf, out_data} !== ex[i]) begin
        nFail++; $display("FAIL directed_%0d: got v=%b %h want 1 %h", i, out_valid, {out_ovf, out_data}, ex[i]);
      end
      nChecks++;
      if (q.size() != 1 || {out_ovf, out_data} !== q[0]) begin
        nFail++; $display("FAIL directed_model_%0d: got %h want %h", i, {out_ovf, out_data}, q.size() ? q[0] : 33'h0);
      end
      tick();
    end
  endtask

  task automatic test_ovf32();
    logic [32:0] e;
    dataW = 32'hC0000000; lenW = 6'd32; signedW = 0; shiftW = 2'd1; validW = 1;
    nChecks++;
    if (readyW !== 1'b1) begin nFail++; $display("FAIL w32_ready: got %b want 1", readyW); end
    @(posedge clk); @(negedge clk);
    nChecks++;
    if (outValidW !== 1'b1 || {outOvfW, outDataW} !== 33'h180000000) begin
      nFail++; $display("FAIL w32_directed: got v=%b %h want 1 180000000", outValidW, {outOvfW, outDataW});
    end
    for (int i = 0; i < 12; i++) begin
      dataW = $urandom; lenW = 6'($urandom_range(0, 34)); signedW = 1'($urandom);
      shiftW = 2'($urandom);
      e = model(longint'(dataW), int'(lenW), 32, signedW, int'(shiftW));
      @(posedge clk); @(negedge clk);
      nChecks++;
      if (outValidW !== 1'b1 || {outOvfW, outDataW} !== e) begin
        nFail++; $display("FAIL w32_random_%0d: got v=%b %h want 1 %h", i, outValidW, {outOvfW, outDataW}, e);
      end
    end
    validW = 0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] ea, eb, ec;
    logic [32:0] got[$];
    bit acc;
    logic [23:0] dv [3] = '{24'h00ABCD, 24'h812345, 24'h000F0F};
    ea = model(longint'(dv[0]), 12, 24, 1, 1);
    eb = model(longint'(dv[1]), 0, 24, 1, 3);
    ec = model(longint'(dv[2]), 9, 24, 0, 2);
    out_ready = 0;
    in_data = dv[0]; in_len = 12; in_signed = 1; in_shift = 1; in_valid = 1;
    nChecks++;
    if (in_ready !== 1'b1) begin nFail++; $display("FAIL bp_ready_a: got %b want 1", in_ready); end
    tick();
    in_data = dv[1]; in_len = 0; in_signed = 1; in_shift = 3;
    nChecks++;
    if (in_ready !== 1'b1) begin nFail++; $display("FAIL bp_ready_b: got %b want 1", in_ready); end
    tick();
    in_data = dv[2]; in_len = 9; in_signed = 0; in_shift = 2;
    nChecks++;
    if (in_ready !== 1'b0 || {out_ovf, out_data} !== ea) begin
      nFail++; $display("FAIL bp_full: got r=%b %h want 0 %h", in_ready, {out_ovf, out_data}, ea);
    end
    tick();
    nChecks++;
    if (out_valid !== 1'b1 || {out_ovf, out_data} !== ea) begin
      nFail++; $display("FAIL bp_stable: got v=%b %h want 1 %h", out_valid, {out_ovf, out_data}, ea);
    end
    out_ready = 1;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      if (out_valid) got.push_back({out_ovf, out_data});
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 0;
    end
    nChecks++;
    if (got.size() != 3) begin
      nFail++; $display("FAIL bp_count: got %0d want 3", got.size());
    end else if (got[0] !== ea || got[1] !== eb || got[2] !== ec) begin
      nFail++; $display("FAIL bp_order: got %h %h %h want %h %h %h", got[0], got[1], got[2], ea, eb, ec);
    end
    in_valid = 0;
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 24'($urandom); in_len = 5'($urandom); in_signed = 1'($urandom);
      in_shift = 2'($urandom); in_valid = 1;
      nChecks++;
      if (in_ready !== 1'b1) begin nFail++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
      tick();
      nChecks++;
      if (out_valid !== 1'b1 || q.size() != 1 || {out_ovf, out_data} !== q[$]) begin
        nFail++; $display("FAIL stream_out_%0d: got v=%b %h want 1 %h", i, out_valid, {out_ovf, out_data}, q.size() ? q[$] : 33'h0);
      end
    end
    in_valid = 0;
    tick();
    nChecks++;
    if (out_valid !== 1'b0) begin nFail++; $display("FAIL stream_end: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data = 24'($urandom); in_len = 5'($urandom); in_signed = 1'($urandom);
      in_shift = 2'($urandom);
      nChecks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != 2)) begin
        nFail++; $display("FAIL rand_flags_%0d: got v=%b r=%b want occupancy %0d", i, out_valid, in_ready, q.size());
      end
      if (q.size() != 0) begin
        nChecks++;
        if ({out_ovf, out_data} !== q[0]) begin
          nFail++; $display("FAIL rand_data_%0d: got %h want %h", i, {out_ovf, out_data}, q[0]);
        end
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1;
    in_data = 24'h123456; in_len = 0; in_signed = 1; in_shift = 3;
    tick();
    in_data = 24'h7FFFFF;
    tick();
    in_valid = 0;
    nChecks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      nFail++; $display("FAIL mid_full: got r=%b v=%b want 0 1", in_ready, out_valid);
    end
    #2 rst_n = 0;
    #1 nChecks++;
    if ({out_valid, in_ready, out_ovf, out_data} !== 35'd0) begin
      nFail++; $display("FAIL mid_reset: got v=%b r=%b o=%b d=%h want all zero", out_valid, in_ready, out_ovf, out_data);
    end
    q.delete();
    #1 rst_n = 1;
    #0 nChecks++;
    if (in_ready !== 1'b0) begin nFail++; $display("FAIL mid_release_early: in_ready=%b want 0", in_ready); end
    @(negedge clk);
    nChecks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nFail++; $display("FAIL mid_release: got r=%b v=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (out_valid !== 1'b0) begin nFail++; $display("FAIL mid_stale_%0d: out_valid=%b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ovf32();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate-extension unit for the multicycle datapath. It replaces fixed-width sign extenders with one block that handles:
- a run-time field width;
- signed or unsigned extension;
- a post-extension left shift, used for word-aligned branch and jump offsets.

Results pass through a 2-entry valid/ready output buffer, so the decode stage can stall without losing an extracted immediate.

## Interface
- IN_W, 24, maximum immediate field width in bits; legal range 1..OUT_W.
- OUT_W, 32, extended result width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  buffer can accept a request this cycle.
- in_data  input  IN_W  raw immediate field, LSB-aligned.
- in_len  input  $clog2(IN_W+1)  active field width in bits.
- in_signed  input  1  1 = sign-extend, 0 = zero-extend.
- in_shift  input  2  left shift applied after extension (0..3).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  OUT_W  extended, shifted immediate.
- out_ovf  output  1  significant bits were lost by the shift.

## Operation
**Field width**
- Effective length L = in_len, with two exceptions:
  - in_len = 0 gives L = IN_W;
  - in_len > IN_W is clamped to IN_W.
- in_data bits at position L and above are ignored.

**Extension**
- Sign bit s = in_data[L-1] when in_signed = 1; otherwise s = 0.
- Extended value E = {(OUT_W-L) copies of s, in_data[L-1:0]}, OUT_W bits wide.

**Shift**
- Result R = E << in_shift, truncated to OUT_W bits, with zero fill from the LSB.
- out_ovf for signed requests: 1 if any bit shifted out of the top differs from R[OUT_W-1].
- out_ovf for unsigned requests: 1 if any bit shifted out of the top is nonzero.
- out_ovf is 0 when in_shift = 0.

**Timing of the datapath**
- R and out_ovf are computed combinationally from the inputs in the accept cycle.
- They are stored in the buffer together.

**Buffer**
- 2-entry FIFO with read pointer, write pointer and a count in {0, 1, 2}.
- Push occurs when in_valid & in_ready.
- Pop occurs when out_valid & out_ready.
- in_ready = (count != 2). It depends only on registered state, never on out_ready.
- out_valid = (count != 0). out_data and out_ovf always show the head entry.
- A push while count = 2 cannot occur, because in_ready is low.
- Simultaneous push and pop at count = 1: the count stays 1, the head advances to the new entry, and there is no bubble.
- Pointers wrap modulo 2.
- out_data and out_ovf must stay stable while out_valid = 1 and out_ready = 0.

**Reset**
- Asserting rst_n = 0 at any time, including mid-transfer, immediately sets:
  - count = 0, both pointers = 0;
  - out_valid = 0, in_ready = 0 while reset is held;
  - out_data = 0, out_ovf = 0.
- Any buffered entries are discarded.
- in_ready rises on the first clk edge after rst_n is released.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on out_* after edge N, provided the buffer was empty.
- Sustained throughput is 1 request per cycle when out_ready is held high.
- Backpressure: with out_ready = 0, two requests are accepted, then in_ready drops on the edge after the second push. It rises again on the edge after the first pop.
- No combinational path exists from out_ready to in_ready, or from in_* to out_*.

## Test plan
- **Signed 14-bit:** IN_W=24, OUT_W=32, in_data=0x002000, in_len=14, in_signed=1, in_shift=0 -> out_data=0xFFFFE000, out_ovf=0, one cycle after accept.
- **Signed 24-bit and unsigned:**
  - in_data=0x800000, in_len=0 (so L=24), signed -> 0xFF800000.
  - Same data, unsigned -> 0x00800000.
  - in_data=0xFF2000, in_len=14, unsigned -> 0x00002000, confirming upper bits are ignored.
- **Shifted offset:** in_data=0x003FFF, in_len=14, signed, in_shift=2 -> 0xFFFFFFFC, out_ovf=0. Separate instance with IN_W=32: in_data=0xC0000000, in_len=32, unsigned, in_shift=1 -> 0x80000000, out_ovf=1.
- **Backpressure:**
  - Hold out_ready=0 and push A, B, C on consecutive cycles -> A and B accepted, in_ready=0 during the C cycle, out_data stays A.
  - Then set out_ready=1 -> A, B, C emerge in order with no loss and no duplication.
- **Streaming:** out_ready=1, push 8 back-to-back requests -> 8 results on 8 consecutive cycles with count never exceeding 1.
- **Reset mid-operation:** fill the buffer (count=2), then pulse rst_n low between edges -> out_valid=0, out_data=0 and out_ovf=0 immediately. After release, in_ready=1 on the next edge and no stale entry ever appears.
